custom_axi_lite_master: RTL and testbench

AXI4-Lite initiator that converts a single-outstanding req/gnt memory-style request port into AXI4-Lite write and read transactions. It is the counterpart of the custom AXI slave IP. It lets a core-side agent (DMA helper, config sequencer, or test driver) drive any AXI4-Lite slave on the SoC interconnect. Only one transaction is in flight at a time; bursts, IDs and out-of-order responses are not supported.

---
 rtl/custom_axi_lite_master.sv | 190 +++++++++++++++++++
 tb/tb_custom_axi_lite_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_axi_lite_master.sv
// AXI4-Lite initiator bridging a single-outstanding req/gnt port onto AW/W/B and AR/R.
// Optional response timeout: define CUSTOM_AXI_LITE_MASTER_TIMEOUT_EN.
module custom_axi_lite_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [1:0]              bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  output logic [ADDR_WIDTH-1:0]   araddr_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  input  logic [1:0]              rresp_i,
  input  logic                    rvalid_i,
  output logic                    rready_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_e;

  state_e                  state_q, state_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   strb_q, strb_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

`ifdef CUSTOM_AXI_LITE_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    timeout_c;
  logic                    idle_rdy_q;

  assign timeout_c = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Response readies stay low through reset, then are high in IDLE to soak up late responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_rdy_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      idle_rdy_q <= 1'b1;
      cnt_q      <= cnt_d;
    end
  end
`endif

  // State and payload registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Next-state and completion logic
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    rvalid_d  = 1'b0;
    rdata_d   = '0;
    err_d     = 1'b0;
`ifdef CUSTOM_AXI_LITE_MASTER_TIMEOUT_EN
    cnt_d     = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          strb_d  = be_i;
          state_d = we_i ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        if (awready_i) aw_done_d = 1'b1;
        if (wready_i)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_RESP: begin
        if (bvalid_i) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          err_d    = bresp_i inside {RESP_SLVERR, RESP_DECERR};
        end
`ifdef CUSTOM_AXI_LITE_MASTER_TIMEOUT_EN
        else if (timeout_c) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
`endif
      end
      RD_REQ: begin
        if (arready_i) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (rvalid_i) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = rdata_i;
          err_d    = rresp_i inside {RESP_SLVERR, RESP_DECERR};
        end
`ifdef CUSTOM_AXI_LITE_MASTER_TIMEOUT_EN
        else if (timeout_c) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_o     = (state_q == IDLE) && req_i;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign awaddr_o  = addr_q;
  assign araddr_o  = addr_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = strb_q;
  assign awvalid_o = (state_q == WR_REQ) && !aw_done_q;
  assign wvalid_o  = (state_q == WR_REQ) && !w_done_q;
  assign arvalid_o = (state_q == RD_REQ);
`ifdef CUSTOM_AXI_LITE_MASTER_TIMEOUT_EN
  assign bready_o  = (state_q == WR_RESP) || ((state_q == IDLE) && idle_rdy_q);
  assign rready_o  = (state_q == RD_RESP) || ((state_q == IDLE) && idle_rdy_q);
`else
  assign bready_o  = (state_q == WR_RESP);
  assign rready_o  = (state_q == RD_RESP);
`endif

endmodule

// File: tb/tb_custom_axi_lite_master.sv
// Directed bench for custom_axi_lite_master; the bench itself plays the AXI slave cycle by cycle.
module tb_custom_axi_lite_master;

`ifdef CUSTOM_AXI_LITE_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic [31:0] awaddr_o, wdata_o, araddr_o;
  logic        awvalid_o, awready_i, wvalid_o, wready_i;
  logic [3:0]  wstrb_o;
  logic [1:0]  bresp_i, rresp_i;
  logic        bvalid_i, bready_o, arvalid_o, arready_i;
  logic [31:0] rdata_i;
  logic        rvalid_i, rready_o;

  int n_checks = 0;
  int n_fails  = 0;

  custom_axi_lite_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic slave_idle();
    awready_i = 1'b0; wready_i = 1'b0;
    bvalid_i = 1'b0;  bresp_i = 2'b00;
    arready_i = 1'b0;
    rvalid_i = 1'b0;  rresp_i = 2'b00; rdata_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
    slave_idle();
    cyc(); cyc();
    chk("rst_awvalid", 32'(awvalid_o), 32'd0);
    chk("rst_wvalid",  32'(wvalid_o),  32'd0);
    chk("rst_arvalid", 32'(arvalid_o), 32'd0);
    chk("rst_bready",  32'(bready_o),  32'd0);
    chk("rst_rready",  32'(rready_o),  32'd0);
    chk("rst_rvalid",  32'(rvalid_o),  32'd0);
    chk("rst_gnt",     32'(gnt_o),     32'd0);
    chk("rst_awaddr",  awaddr_o,       32'd0);
    chk("rst_rdata",   rdata_o,        32'd0);
    #2 rst_ni = 1'b1;
    cyc();

    // Zero-wait write, OKAY
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h1000_0004; wdata_i = 32'hDEAD_BEEF; be_i = 4'hF;
    #1 chk("w1_gnt", 32'(gnt_o), 32'd1);
    cyc();
    req_i = 1'b0; awready_i = 1'b1; wready_i = 1'b1;
    #1;
    chk("w1_awvalid", 32'(awvalid_o), 32'd1);
    chk("w1_wvalid",  32'(wvalid_o),  32'd1);
    chk("w1_awaddr",  awaddr_o, 32'h1000_0004);
    chk("w1_wdata",   wdata_o,  32'hDEAD_BEEF);
    chk("w1_wstrb",   32'(wstrb_o), 32'hF);
    chk("w1_gnt_busy", 32'(gnt_o), 32'd0);
    cyc();
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b1; bresp_i = 2'b00;
    #1;
    chk("w1_bready",  32'(bready_o),  32'd1);
    chk("w1_aw_drop", 32'(awvalid_o), 32'd0);
    chk("w1_w_drop",  32'(wvalid_o),  32'd0);
    cyc();
    bvalid_i = 1'b0;
    #1;
    chk("w1_rvalid", 32'(rvalid_o), 32'd1);
    chk("w1_err",    32'(err_o),    32'd0);
    chk("w1_rdata",  rdata_o,       32'd0);
    cyc();
    chk("w1_pulse_end", 32'(rvalid_o), 32'd0);

    // Write where W completes three cycles before AW, EXOKAY response
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h40; wdata_i = 32'hA5A5_0F0F; be_i = 4'h3;
    #1 chk("w2_gnt", 32'(gnt_o), 32'd1);
    cyc();
    req_i = 1'b0; wready_i = 1'b1;
    #1;
    chk("w2_awvalid_n1", 32'(awvalid_o), 32'd1);
    chk("w2_wvalid_n1",  32'(wvalid_o),  32'd1);
    cyc();
    wready_i = 1'b0;
    #1;
    chk("w2_wvalid_drop", 32'(wvalid_o),  32'd0);
    chk("w2_awvalid_hold", 32'(awvalid_o), 32'd1);
    chk("w2_wstrb",       32'(wstrb_o),   32'h3);
    cyc();
    chk("w2_awvalid_n3", 32'(awvalid_o), 32'd1);
    chk("w2_wvalid_n3",  32'(wvalid_o),  32'd0);
    cyc();
    awready_i = 1'b1;
    #1 chk("w2_awvalid_n4", 32'(awvalid_o), 32'd1);
    cyc();
    awready_i = 1'b0; bvalid_i = 1'b1; bresp_i = 2'b01;
    #1;
    chk("w2_awvalid_drop", 32'(awvalid_o), 32'd0);
    chk("w2_bready",       32'(bready_o),  32'd1);
    chk("w2_no_early_rv",  32'(rvalid_o),  32'd0);
    cyc();
    bvalid_i = 1'b0; bresp_i = 2'b00;
    #1;
    chk("w2_rvalid", 32'(rvalid_o), 32'd1);
    chk("w2_err",    32'(err_o),    32'd0);
    cyc();
    chk("w2_pulse_end", 32'(rvalid_o), 32'd0);
    chk("w2_bready_idle", 32'(bready_o), 32'(TO_EN));

    // Read with 4-cycle R delay, SLVERR
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h20;
    #1 chk("r1_gnt", 32'(gnt_o), 32'd1);
    cyc();
    req_i = 1'b0; arready_i = 1'b1;
    #1;
    chk("r1_arvalid", 32'(arvalid_o), 32'd1);
    chk("r1_araddr",  araddr_o,       32'h20);
    cyc();
    arready_i = 1'b0;
    #1;
    chk("r1_ar_drop", 32'(arvalid_o), 32'd0);
    chk("r1_rready",  32'(rready_o),  32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("r1_wait_rready", 32'(rready_o), 32'd1);
      chk("r1_wait_rvalid", 32'(rvalid_o), 32'd0);
    end
    cyc();
    rvalid_i = 1'b1; rdata_i = 32'h1234_5678; rresp_i = 2'b10;
    cyc();
    rvalid_i = 1'b0; rdata_i = '0; rresp_i = 2'b00;
    #1;
    chk("r1_rvalid", 32'(rvalid_o), 32'd1);
    chk("r1_rdata",  rdata_o,       32'h1234_5678);
    chk("r1_err",    32'(err_o),    32'd1);
    cyc();
    chk("r1_pulse_end", 32'(rvalid_o), 32'd0);
    chk("r1_rdata_clr", rdata_o,       32'd0);

    // Back-to-back write then read with req_i held high
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h100; wdata_i = 32'h1122_3344; be_i = 4'hF;
    #1 chk("bb_gnt1", 32'(gnt_o), 32'd1);
    cyc();
    we_i = 1'b0; addr_i = 32'h104; awready_i = 1'b1; wready_i = 1'b1;
    #1;
    chk("bb_gnt_busy1", 32'(gnt_o),     32'd0);
    chk("bb_awvalid",   32'(awvalid_o), 32'd1);
    chk("bb_awaddr",    awaddr_o,       32'h100);
    cyc();
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b1;
    #1;
    chk("bb_gnt_busy2", 32'(gnt_o),     32'd0);
    chk("bb_no_ar",     32'(arvalid_o), 32'd0);
    cyc();
    bvalid_i = 1'b0;
    #1;
    chk("bb_rvalid1", 32'(rvalid_o), 32'd1);
    chk("bb_gnt2",    32'(gnt_o),    32'd1);
    cyc();
    req_i = 1'b0; arready_i = 1'b1;
    #1;
    chk("bb_arvalid",  32'(arvalid_o), 32'd1);
    chk("bb_araddr",   araddr_o,       32'h104);
    chk("bb_rv1_end",  32'(rvalid_o),  32'd0);
    chk("bb_no_aw",    32'(awvalid_o), 32'd0);
    cyc();
    arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'hCAFE_F00D; rresp_i = 2'b00;
    #1 chk("bb_rready", 32'(rready_o), 32'd1);
    cyc();
    rvalid_i = 1'b0; rdata_i = '0;
    #1;
    chk("bb_rvalid2", 32'(rvalid_o), 32'd1);
    chk("bb_rdata2",  rdata_o,       32'hCAFE_F00D);
    chk("bb_err2",    32'(err_o),    32'd0);
    cyc();

    // Reset while waiting for B
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h200; wdata_i = 32'h55AA_55AA; be_i = 4'hF;
    cyc();
    req_i = 1'b0; awready_i = 1'b1; wready_i = 1'b1;
    cyc();
    awready_i = 1'b0; wready_i = 1'b0;
    #1 chk("rs_bready_pre", 32'(bready_o), 32'd1);
    #2 rst_ni = 1'b0;
    slave_idle();
    #1;
    chk("rs_bready",  32'(bready_o), 32'd0);
    chk("rs_awaddr",  awaddr_o,      32'd0);
    chk("rs_wdata",   wdata_o,       32'd0);
    chk("rs_rvalid",  32'(rvalid_o), 32'd0);
    cyc();
    chk("rs_rvalid_hold", 32'(rvalid_o), 32'd0);
    #2 rst_ni = 1'b1;
    cyc();
    chk("rs_rvalid_after", 32'(rvalid_o), 32'd0);
    chk("rs_bready_after", 32'(bready_o), 32'(TO_EN));
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h300;
    #1 chk("rs_gnt", 32'(gnt_o), 32'd1);
    cyc();
    req_i = 1'b0; arready_i = 1'b1;
    #1 chk("rs_arvalid", 32'(arvalid_o), 32'd1);
    cyc();
    arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h0BAD_C0DE; rresp_i = 2'b11;
    cyc();
    rvalid_i = 1'b0; rdata_i = '0; rresp_i = 2'b00;
    #1;
    chk("rs_rvalid_new", 32'(rvalid_o), 32'd1);
    chk("rs_rdata_new",  rdata_o,       32'h0BAD_C0DE);
    chk("rs_err_decerr", 32'(err_o),    32'd1);
    cyc();

`ifdef CUSTOM_AXI_LITE_MASTER_TIMEOUT_EN
    // Read that never gets R: times out 16 cycles after RD_RESP entry
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h400;
    cyc();
    req_i = 1'b0; arready_i = 1'b1;
    cyc();
    arready_i = 1'b0;
    #1 chk("to_rready", 32'(rready_o), 32'd1);
    for (int i = 1; i < 16; i++) begin
      cyc();
      chk("to_wait_rvalid", 32'(rvalid_o), 32'd0);
    end
    cyc();
    chk("to_rvalid", 32'(rvalid_o), 32'd1);
    chk("to_err",    32'(err_o),    32'd1);
    chk("to_rdata",  rdata_o,       32'd0);
    cyc();
    rvalid_i = 1'b1; rdata_i = 32'hFFFF_FFFF; rresp_i = 2'b00;
    #1;
    chk("to_idle_rready", 32'(rready_o), 32'd1);
    chk("to_pulse_end",   32'(rvalid_o), 32'd0);
    cyc();
    rvalid_i = 1'b0; rdata_i = '0;
    #1;
    chk("to_stray_absorbed", 32'(rvalid_o), 32'd0);
    chk("to_stray_gnt",      32'(gnt_o),    32'd0);
    cyc();
    chk("to_stray_quiet",    32'(rvalid_o), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
